riscv2consumer_bank: RTL and testbench
======================================

Name: riscv2consumer_bank

Overview:
- Parametrised successor of the single-channel riscv2consumer stage: one instance replaces the per-port copies that sit between the soft-core memory-mapped stream ports and downstream operators.
- Provides NUM_PORTS independent buffered stream channels, each a DEPTH-entry FIFO, on packed buses.
- Adds per-channel flush, occupancy reporting and a global idle flag; the original had no buffering depth or status.
- Channel i always uses slice i of every packed bus, so no cross-wiring between channels is possible.

Parameters:
- NUM_PORTS, 5, number of independent channels (1..16).
- DATA_WIDTH, 32, payload width per channel.
- DEPTH, 4, FIFO entries per channel; must be a power of two, 2..64.
- CNT_W, $clog2(DEPTH)+1, local parameter (not overridable); width of each occupancy count.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  NUM_PORTS*DATA_WIDTH  write data; channel i is bits [i*DATA_WIDTH +: DATA_WIDTH].
- val_in  input  NUM_PORTS  per-channel write valid from the processor side.
- ready_upward  output  NUM_PORTS  per-channel ready to the processor side.
- dout  output  NUM_PORTS*DATA_WIDTH  FIFO head data per channel; same slicing as din.
- val_out  output  NUM_PORTS  per-channel valid to the consumer.
- ready_downward  input  NUM_PORTS  per-channel ready from the consumer.
- flush  input  NUM_PORTS  per-channel synchronous clear of FIFO contents.
- count  output  NUM_PORTS*CNT_W  per-channel occupancy, 0..DEPTH.
- idle  output  1  high when every channel count is 0.

Behaviour:
- Reset values: count=0, val_out=0, ready_upward=all ones from the first cycle after reset, idle=1, dout=0 (head register cleared).
- During reset, val_in and ready_downward are ignored.
- Per-channel state: DEPTH x DATA_WIDTH storage, read pointer and write pointer of $clog2(DEPTH) bits, and a CNT_W-bit count.
- Pointers wrap modulo DEPTH naturally.
- ready_upward[i] = (count_i != DEPTH) and not reset. It depends on registered state only; it is never combinational on ready_downward.
- val_out[i] = (count_i != 0). dout[i] shows the head entry (first-word fall-through, no read latency).
- push_i = val_in[i] & ready_upward[i]. Writes din slice at wptr; wptr increments.
- pop_i = val_out[i] & ready_downward[i]. Increments rptr.
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged; read and write proceed together.
- Latency: a push in cycle N gives val_out=1 with that data in cycle N+1. Minimum input-to-output latency is 1 cycle, with no bypass path.
- Throughput: 1 word per cycle per channel while 0 < count < DEPTH, and also at count=0 with push-only.
- Full (count=DEPTH): ready_upward=0; push is blocked even if a pop occurs in the same cycle. ready_upward reasserts the cycle after the pop.
- Empty: val_out=0. dout holds the stale head value; consumers must not sample dout while val_out is low.
- flush[i]:
  - Highest priority within its channel. Next cycle: count_i=0 and rptr=wptr=0.
  - A push or pop in the same cycle is discarded. ready_upward and val_out still follow the pre-flush count in that cycle.
  - Other channels are unaffected.
- Reset mid-operation clears all channels identically to flush and overrides it.
- Ordering is strict FIFO per channel. Channels are fully independent, with no shared arbitration.
- idle is registered state only: the AND of (count_i==0) over all channels.

Test Plan:
- Reset, then write 0x11,0x22,0x33 on channel 0 with ready_downward[0]=1 → val_out[0] rises 1 cycle after the first push, dout0 = 0x11,0x22,0x33 on consecutive cycles, count0 ≤ 1 throughout, idle returns to 1.
- DEPTH=4 on channel 2, ready_downward[2]=0, val_in[2] held high with data 1..6 → exactly 1..4 accepted; ready_upward[2]=0 with count2=4; raising ready_downward drains 1,2,3,4 then 5,6 in order with no loss or duplicates.
- Channel 3 at count=4, assert val_in and ready_downward together → pop only, count becomes 3; next cycle a push and a pop together keep count at 3.
- Channel 1 holding 3 words, assert flush[1] together with a push of 0xAA → next cycle count1=0 and val_out[1]=0; 0xAA is never output; channel 4 traffic continues uninterrupted.
- Distinct streams 0xC0+i on all 5 channels with random ready_downward (50%) → each dout slice carries only its own channel's data, in order; this specifically checks channel 3 is not aliased to channel 0.
- Assert reset while channels are partly full → all counts 0, val_out=0 and idle=1 in the next cycle; the first post-reset push is output normally.

Source files
------------

// File: rtl/riscv2consumer_bank.sv
// Bank of NUM_PORTS independent first-word-fall-through stream FIFOs, with
// per-channel flush, occupancy counts and a global idle flag.
module riscv2consumer_bank #(
    parameter int unsigned  NUM_PORTS  = 5,
    parameter int unsigned  DATA_WIDTH = 32,
    parameter int unsigned  DEPTH      = 4,
    localparam int unsigned CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] din,
    input  logic [NUM_PORTS-1:0]            val_in,
    output logic [NUM_PORTS-1:0]            ready_upward,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] dout,
    output logic [NUM_PORTS-1:0]            val_out,
    input  logic [NUM_PORTS-1:0]            ready_downward,
    input  logic [NUM_PORTS-1:0]            flush,
    output logic [NUM_PORTS*CNT_W-1:0]      count,
    output logic                            idle
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [NUM_PORTS-1:0] busy_d;
    logic                 idle_q;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      rptr_q;
        logic [PTR_W-1:0]      wptr_q;
        logic [CNT_W-1:0]      cnt_q;
        logic [CNT_W-1:0]      cnt_d;
        logic                  push;
        logic                  pop;

        // Handshakes depend only on registered occupancy (plus reset).
        assign ready_upward[g] = (cnt_q != CNT_W'(DEPTH)) && !reset;
        assign val_out[g]      = (cnt_q != '0);
        assign push            = val_in[g] & ready_upward[g];
        assign pop             = val_out[g] & ready_downward[g];

        always_comb begin
            cnt_d = cnt_q;
            if (reset || flush[g]) begin
                cnt_d = '0;
            end else if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Reset also clears storage so the head reads zero afterwards.
        always_ff @(posedge clk) begin
            if (reset) begin
                rptr_q <= '0;
                wptr_q <= '0;
                for (int unsigned k = 0; k < DEPTH; k++) begin
                    mem_q[k] <= '0;
                end
            end else if (flush[g]) begin
                rptr_q <= '0;
                wptr_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wptr_q] <= din[g*DATA_WIDTH +: DATA_WIDTH];
                    wptr_q        <= wptr_q + PTR_W'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PTR_W'(1);
                end
            end
            cnt_q <= cnt_d;
        end

        assign busy_d[g]                         = (cnt_d != '0);
        assign dout[g*DATA_WIDTH +: DATA_WIDTH]  = mem_q[rptr_q];
        assign count[g*CNT_W +: CNT_W]           = cnt_q;
    end

    // Idle mirrors the registered counts, so it is computed from next-state.
    always_ff @(posedge clk) begin
        idle_q <= ~|busy_d;
    end

    assign idle = idle_q;

endmodule

// File: tb/tb_riscv2consumer_bank.sv
// Randomised and directed bench for riscv2consumer_bank against a queue-based
// model of per-channel FIFO behaviour.
module tb_riscv2consumer_bank;
    localparam int NP    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [NP*DW-1:0] din;
    logic [NP-1:0]    val_in;
    logic [NP-1:0]    ready_upward;
    logic [NP*DW-1:0] dout;
    logic [NP-1:0]    val_out;
    logic [NP-1:0]    ready_downward;
    logic [NP-1:0]    flush;
    logic [NP*CW-1:0] count;
    logic             idle;

    logic [DW-1:0] mq [NP][$];
    int vectors = 0;
    int miscompares = 0;

    riscv2consumer_bank #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .din           (din),
        .val_in        (val_in),
        .ready_upward  (ready_upward),
        .dout          (dout),
        .val_out       (val_out),
        .ready_downward(ready_downward),
        .flush         (flush),
        .count         (count),
        .idle          (idle)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] dsl(int i);
        return dout[i*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] csl(int i);
        return count[i*CW +: CW];
    endfunction

    function automatic bit model_idle();
        for (int i = 0; i < NP; i++) if (mq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Advance one clock: apply the FIFO rules to the model, then return at negedge.
    task automatic tick();
        bit            push [NP];
        bit            pop  [NP];
        logic [DW-1:0] d    [NP];
        for (int i = 0; i < NP; i++) begin
            push[i] = val_in[i] && !reset && (mq[i].size() != DEPTH);
            pop[i]  = ready_downward[i] && !reset && (mq[i].size() != 0);
            d[i]    = din[i*DW +: DW];
        end
        @(posedge clk);
        for (int i = 0; i < NP; i++) begin
            if (reset || flush[i]) begin
                mq[i].delete();
            end else begin
                if (pop[i]) void'(mq[i].pop_front());
                if (push[i]) mq[i].push_back(d[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic quiet();
        val_in = '0; ready_downward = '0; flush = '0; din = '0; reset = 1'b0;
    endtask

    task automatic drain();
        quiet();
        ready_downward = '1;
        for (int k = 0; k < DEPTH + 1; k++) tick();
        quiet();
    endtask

    task automatic test_reset();
        quiet();
        reset = 1'b1;
        #1;
        vectors++;
        if (ready_upward !== '0) begin
            miscompares++;
            $display("FAIL reset_ready_low: got %b want %b", ready_upward, 5'b0);
        end
        tick();
        tick();
        reset = 1'b0;
        #1;
        vectors++;
        if (count !== '0 || val_out !== '0 || idle !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_state: count=%h val_out=%b idle=%b want 0/0/1", count, val_out, idle);
        end
        vectors++;
        if (ready_upward !== '1 || dout !== '0) begin
            miscompares++;
            $display("FAIL reset_ready_dout: ready=%b dout=%h want 11111/0", ready_upward, dout);
        end
    endtask

    task automatic test_basic();
        logic [DW-1:0] d3 [3] = '{32'h11, 32'h22, 32'h33};
        drain();
        ready_downward[0] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            val_in[0] = (k < 3);
            din[0 +: DW] = (k < 3) ? d3[k] : '0;
            #1;
            vectors++;
            if (val_out[0] !== (k >= 1 && k <= 3) || csl(0) > CW'(1)) begin
                miscompares++;
                $display("FAIL basic_val k=%0d: val=%b count=%0d", k, val_out[0], csl(0));
            end
            if (k >= 1 && k <= 3) begin
                vectors++;
                if (dsl(0) !== d3[k-1]) begin
                    miscompares++;
                    $display("FAIL basic_dout k=%0d: got %h want %h", k, dsl(0), d3[k-1]);
                end
            end
            tick();
        end
        #1;
        vectors++;
        if (idle !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_idle: got %b want 1", idle);
        end
    endtask

    task automatic test_full();
        int nxt = 1;
        logic [DW-1:0] got [$];
        drain();
        for (int k = 0; k < 6; k++) begin
            val_in[2] = 1'b1;
            din[2*DW +: DW] = DW'(nxt);
            #1;
            vectors++;
            if (ready_upward[2] !== (mq[2].size() != DEPTH)) begin
                miscompares++;
                $display("FAIL full_ready k=%0d: got %b want %b", k, ready_upward[2], mq[2].size() != DEPTH);
            end
            if (mq[2].size() != DEPTH) nxt++;
            tick();
        end
        #1;
        vectors++;
        if (csl(2) !== CW'(4) || ready_upward[2] !== 1'b0 || nxt != 5) begin
            miscompares++;
            $display("FAIL full_state: count=%0d ready=%b accepted=%0d want 4/0/4", csl(2), ready_upward[2], nxt - 1);
        end
        ready_downward[2] = 1'b1;
        for (int k = 0; k < 20 && got.size() < 6; k++) begin
            val_in[2] = (nxt <= 6);
            din[2*DW +: DW] = DW'(nxt);
            #1;
            if (val_out[2]) got.push_back(dsl(2));
            if (nxt <= 6 && mq[2].size() != DEPTH) nxt++;
            tick();
        end
        vectors++;
        if (got.size() != 6) begin
            miscompares++;
            $display("FAIL full_drain_len: got %0d words want 6", got.size());
        end
        for (int k = 0; k < got.size(); k++) begin
            vectors++;
            if (got[k] !== DW'(k + 1)) begin
                miscompares++;
                $display("FAIL full_order[%0d]: got %h want %h", k, got[k], k + 1);
            end
        end
    endtask

    task automatic test_full_pop();
        drain();
        for (int k = 0; k < 4; k++) begin
            val_in[3] = 1'b1;
            din[3*DW +: DW] = DW'(32'h30 + k);
            tick();
        end
        val_in[3] = 1'b1;
        ready_downward[3] = 1'b1;
        din[3*DW +: DW] = 32'h3F;
        #1;
        vectors++;
        if (ready_upward[3] !== 1'b0 || csl(3) !== CW'(4)) begin
            miscompares++;
            $display("FAIL fullpop_pre: ready=%b count=%0d want 0/4", ready_upward[3], csl(3));
        end
        tick();
        #1;
        vectors++;
        if (csl(3) !== CW'(3) || ready_upward[3] !== 1'b1 || dsl(3) !== 32'h31) begin
            miscompares++;
            $display("FAIL fullpop_one: count=%0d ready=%b dout=%h want 3/1/31", csl(3), ready_upward[3], dsl(3));
        end
        tick();
        #1;
        vectors++;
        if (csl(3) !== CW'(3) || dsl(3) !== 32'h32) begin
            miscompares++;
            $display("FAIL fullpop_both: count=%0d dout=%h want 3/32", csl(3), dsl(3));
        end
    endtask

    task automatic test_flush();
        drain();
        ready_downward[4] = 1'b1;
        for (int k = 0; k < 9; k++) begin
            val_in[4] = 1'b1;
            din[4*DW +: DW] = DW'(32'h400 + k);
            val_in[1] = (k < 4);
            din[1*DW +: DW] = (k == 3) ? 32'hAA : DW'(32'h100 + k);
            flush[1] = (k == 3);
            ready_downward[1] = (k > 3);
            #1;
            if (k == 3) begin
                vectors++;
                if (ready_upward[1] !== 1'b1 || val_out[1] !== 1'b1 || csl(1) !== CW'(3)) begin
                    miscompares++;
                    $display("FAIL flush_same_cycle: ready=%b val=%b count=%0d want 1/1/3", ready_upward[1], val_out[1], csl(1));
                end
            end
            if (k > 3) begin
                vectors++;
                if (csl(1) !== '0 || val_out[1] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_cleared k=%0d: count=%0d val=%b want 0/0", k, csl(1), val_out[1]);
                end
            end
            vectors++;
            if (k > 0 && (val_out[4] !== 1'b1 || dsl(4) !== DW'(32'h400 + k - 1))) begin
                miscompares++;
                $display("FAIL flush_other_ch k=%0d: val=%b dout=%h want 1/%h", k, val_out[4], dsl(4), 32'h400 + k - 1);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int seq [NP];
        drain();
        for (int i = 0; i < NP; i++) seq[i] = 0;
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NP; i++) begin
                val_in[i] = 1'($urandom_range(0, 3) != 0);
                ready_downward[i] = 1'($urandom_range(0, 1));
                din[i*DW +: DW] = {8'(8'hC0 + i), 24'(seq[i])};
                if (val_in[i] && mq[i].size() != DEPTH) seq[i]++;
            end
            #1;
            for (int i = 0; i < NP; i++) begin
                vectors++;
                if (csl(i) !== CW'(mq[i].size()) || val_out[i] !== (mq[i].size() != 0) ||
                    ready_upward[i] !== (mq[i].size() != DEPTH)) begin
                    miscompares++;
                    $display("FAIL rand_state c=%0d ch%0d: count=%0d val=%b rdy=%b want count %0d",
                             c, i, csl(i), val_out[i], ready_upward[i], mq[i].size());
                end
                if (mq[i].size() != 0) begin
                    vectors++;
                    if (dsl(i) !== mq[i][0]) begin
                        miscompares++;
                        $display("FAIL rand_dout c=%0d ch%0d: got %h want %h", c, i, dsl(i), mq[i][0]);
                    end
                end
            end
            vectors++;
            if (idle !== model_idle()) begin
                miscompares++;
                $display("FAIL rand_idle c=%0d: got %b want %b", c, idle, model_idle());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        quiet();
        for (int k = 0; k < 3; k++) begin
            val_in = '1;
            for (int i = 0; i < NP; i++) din[i*DW +: DW] = $urandom;
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        val_in = '0;
        val_in[0] = 1'b1;
        din[0 +: DW] = 32'h5A;
        #1;
        vectors++;
        if (count !== '0 || val_out !== '0 || idle !== 1'b1 || dout !== '0) begin
            miscompares++;
            $display("FAIL midreset_state: count=%h val=%b idle=%b dout=%h want 0/0/1/0", count, val_out, idle, dout);
        end
        tick();
        val_in = '0;
        #1;
        vectors++;
        if (val_out[0] !== 1'b1 || dsl(0) !== 32'h5A || csl(0) !== CW'(1) || idle !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_push: val=%b dout=%h count=%0d idle=%b want 1/5a/1/0", val_out[0], dsl(0), csl(0), idle);
        end
    endtask

    initial begin
        quiet();
        @(negedge clk);
        test_reset();
        test_basic();
        test_full();
        test_full_pop();
        test_flush();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
